imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes instruction memory through the fetch stage's instruction-memory write port (WriteData / WriteEnable). It is the writer to the fetch stage's reader.
- Accepts a byte stream over a valid/ready handshake: 16-bit word-count header, then big-endian 32-bit instruction words.
- Writes each assembled word to consecutive word addresses.
- Holds the pipeline (PC and IF/ID) frozen while loading, and releases it only after a clean load.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word-aligned.
- MAX_WORDS, 1024, largest accepted word count; a header above this is an error.

Ports:
- Clk  input  1  single clock; all state changes on posedge.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that begins a load; accepted only in IDLE, DONE or ERR.
- ByteIn  input  8  stream byte.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader accepts a byte this cycle.
- WriteData  output  32  assembled instruction word to instruction memory.
- WriteAddress  output  32  byte address for WriteData.
- WriteEnable  output  1  one-cycle write strobe.
- CpuHold  output  1  freezes PC and IF/ID; high from Start until DONE.
- Done  output  1  load completed cleanly; sticky until the next Start.
- Error  output  1  load aborted; sticky until the next Start.

## Operation
- States: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + Start → HDR_HI:
  - Clear Done and Error.
  - Set CpuHold.
  - Load the address counter with BASE_ADDR.
  - Clear the byte index and the running checksum.
- HDR_HI: accept count[15:8] → HDR_LO.
- HDR_LO: accept count[7:0], then:
  - count > MAX_WORDS → ERR.
  - count == 0 → CSUM when checksumming is enabled, otherwise DONE.
  - else → DATA.
- DATA:
  - Bytes arrive MSB first and shift into a 32-bit assembly register.
  - On the 4th byte, write the word, add 4 to the address counter and decrement the remaining-word count.
  - After the last word → CSUM (or DONE).
- CSUM: accept one byte and compare it with the checksum (see Configuration); match → DONE, else → ERR.
- DONE: CpuHold = 0, Done = 1.
- ERR: CpuHold stays 1 so the CPU never executes a partial image; Error = 1.
- Start in any other state is ignored.
- Address arithmetic is 32-bit modulo; the count is unsigned 16-bit.

## Timing
- Reset values: ByteReady = 0, WriteEnable = 0, WriteData = 0, WriteAddress = BASE_ADDR, CpuHold = 0, Done = 0, Error = 0, state = IDLE.
- ByteReady is a registered output, high exactly in HDR_HI, HDR_LO, DATA and CSUM. It is asserted the cycle after Start is sampled.
- A transfer happens when ByteValid && ByteReady at a posedge. ByteValid may drop between bytes with no loss.
- Write timing: WriteEnable, WriteData and WriteAddress are registered.
  - The strobe is high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - WriteAddress for word k is BASE_ADDR + 4k.
  - Back-to-back words at full rate (one byte per cycle) give a strobe every 4 cycles.
- Exit timing:
  - CpuHold falls in the same cycle that Done rises: the cycle after the final accepted byte, or after the final write strobe when checksumming is disabled.
  - Error rises the cycle after the offending header or checksum byte.
- Reset asserted mid-load aborts immediately to the reset values; words already written stay in memory.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A running XOR of every payload byte (header excluded) is kept.
  - A trailing checksum byte is expected in CSUM; a mismatch → ERR.
- Not defined: the CSUM state and checksum register are absent, the payload end → DONE directly, and Error is raised only by count overflow.

## Structure
- Shared package mips_pkg holds:
  - the loader state enum;
  - HDR_BYTES = 2 and BYTES_PER_WORD = 4;
  - the word-address increment constant (4).
- Sub-module byte_assembler: 8-to-32 shift register with a 2-bit byte index and a word_ready pulse.
- The FSM, counters and output registers stay in imem_loader.

## Test plan
- Nominal load, checksum off:
  - Stimulus: Start; stream 00 02, then 20 08 00 05 and AC 01 00 04.
  - Required: writes 32'h20080005 @0x0 and 32'hAC010004 @0x4; Done = 1 and CpuHold = 0 one cycle after the last strobe.
- Throttled stream:
  - Stimulus: same data with ByteValid low on alternate cycles.
  - Required: identical writes and addresses, and no duplicate strobe.
- Count overflow: header 04 01 with MAX_WORDS = 1024 → Error = 1, CpuHold = 1, no WriteEnable.
- Zero count: header 00 00 → Done next cycle, no writes, WriteAddress = BASE_ADDR.
- Checksum, LOADER_CHECKSUM_EN defined:
  - Stimulus: one word 01 02 04 08.
  - Required: checksum byte 0F → Done; checksum byte 0E → Error.
- Reset and Start handling:
  - Stimulus: Rst_n pulsed low after the 2nd payload byte, then a fresh Start.
  - Required: all outputs at their reset values within the reset cycle; the next load starts again at BASE_ADDR.
  - Start pulsed mid-DATA is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared loader state enum and framing constants
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    localparam int          HDR_BYTES      = 2;
    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] WORD_ADDR_INC  = 32'd4;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - 8-to-32 MSB-first shift register with word_ready pulse
module byte_assembler
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_en) begin
            shift_d = {shift_q[15:0], byte_in};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // The 4th byte completes the word combinationally; the caller registers it.
    assign word       = {shift_q, byte_in};
    assign word_ready = byte_en && !clr && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction-memory loader; LOADER_CHECKSUM_EN adds trailing XOR checksum
module imem_loader
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic [31:0] WriteData,
    output logic [31:0] WriteAddress,
    output logic        WriteEnable,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error
);

    loader_state_e state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  hdr_hi_q, hdr_hi_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] waddr_q, waddr_d;
    logic        we_q, we_d;
    logic        byte_ready_q, byte_ready_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        xfer, start_ok, asm_en, word_ready;
    logic [31:0] asm_word;
    logic [15:0] hdr_count;

    assign xfer      = ByteValid && byte_ready_q;
    assign start_ok  = Start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign asm_en    = xfer && (state_q == ST_DATA);
    assign hdr_count = {hdr_hi_q, ByteIn};

    byte_assembler u_asm (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .clr       (start_ok),
        .byte_en   (asm_en),
        .byte_in   (ByteIn),
        .word      (asm_word),
        .word_ready(word_ready)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hdr_hi_d = hdr_hi_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) begin
                    state_d = ST_HDR_HI;
                    addr_d  = BASE_ADDR;
                    waddr_d = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_HDR_HI: begin
                if (xfer) begin
                    hdr_hi_d = ByteIn;
                    state_d  = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    count_d = hdr_count;
                    if (32'(hdr_count) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (asm_en) csum_d = csum_q ^ ByteIn;
`endif
                if (word_ready) begin
                    we_d    = 1'b1;
                    wdata_d = asm_word;
                    waddr_d = addr_q;
                    addr_d  = addr_q + WORD_ADDR_INC;
                    count_d = count_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    if (count_q == 16'd1) state_d = ST_CSUM;
`endif
                end
`ifndef LOADER_CHECKSUM_EN
                // Linger one cycle after the last strobe so Done follows the write.
                if (count_q == 16'd0) state_d = ST_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) state_d = (ByteIn == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        byte_ready_d = (state_d inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CSUM})
                       && !((state_d == ST_DATA) && (count_d == 16'd0));
        hold_d       = !(state_d inside {ST_IDLE, ST_DONE});
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            hdr_hi_q     <= '0;
            addr_q       <= BASE_ADDR;
            wdata_q      <= '0;
            waddr_q      <= BASE_ADDR;
            we_q         <= 1'b0;
            byte_ready_q <= 1'b0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            hdr_hi_q     <= hdr_hi_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            we_q         <= we_d;
            byte_ready_q <= byte_ready_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign ByteReady    = byte_ready_q;
    assign WriteData    = wdata_q;
    assign WriteAddress = waddr_q;
    assign WriteEnable  = we_q;
    assign CpuHold      = hold_q;
    assign Done         = done_q;
    assign Error        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  ByteIn = '0;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic [31:0] WriteData;
    logic [31:0] WriteAddress;
    logic        WriteEnable;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    imem_loader dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Start       (Start),
        .ByteIn      (ByteIn),
        .ByteValid   (ByteValid),
        .ByteReady   (ByteReady),
        .WriteData   (WriteData),
        .WriteAddress(WriteAddress),
        .WriteEnable (WriteEnable),
        .CpuHold     (CpuHold),
        .Done        (Done),
        .Error       (Error)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cyc = -1;
    logic [63:0] got_w[$];
    int          strobe_c[$];
    logic [63:0] exp_w[$];
    logic        exp_done, exp_err;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (WriteEnable) begin
            got_w.push_back({WriteAddress, WriteData});
            strobe_c.push_back(cyc);
        end
        if (Done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] pay_xor(input logic [7:0] s[$]);
        logic [7:0] x = '0;
        for (int i = 2; i < s.size(); i++) x ^= s[i];
        return x;
    endfunction

    // Reference: the stream is header, payload, optional checksum byte.
    task automatic model(input logic [7:0] s[$]);
        int cnt;
        logic [7:0] x;
        exp_w.delete();
        cnt = {s[0], s[1]};
        if (cnt > MAXW) begin
            exp_err = 1'b1;
            exp_done = 1'b0;
            return;
        end
        x = '0;
        for (int k = 0; k < cnt; k++) begin
            exp_w.push_back({BASE + 32'(4 * k), s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]});
            for (int j = 0; j < 4; j++) x ^= s[2+4*k+j];
        end
`ifdef LOADER_CHECKSUM_EN
        exp_done = (s[2+4*cnt] == x);
`else
        exp_done = 1'b1;
`endif
        exp_err = !exp_done;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input bit throttle);
        int t = 0;
        if (throttle) begin
            ByteValid = 1'b0;
            @(posedge Clk); #1;
        end
        ByteIn = b;
        ByteValid = 1'b1;
        forever begin
            @(negedge Clk);
            if (ByteReady) break;
            t++;
            if (t > 40) break;
        end
        chk({tag, ".ready_timeout"}, 32'(t > 40), 32'd0);
        @(posedge Clk); #1;
    endtask

    // mode 0 full rate, 1 alternate-cycle valid, 2 random gaps
    task automatic run_load(input string tag, input logic [7:0] s[$], input int mode, input int start_at);
        int w;
        model(s);
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        got_w.delete();
        strobe_c.delete();
        done_cyc = -1;
        foreach (s[i]) begin
            if (i == start_at) begin
                ByteValid = 1'b0;
                Start = 1'b1;
                @(posedge Clk); #1;
                Start = 1'b0;
            end
            send_byte(tag, s[i], (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1));
        end
        ByteValid = 1'b0;
        w = 0;
        while (!(Done || Error) && w < 40) begin
            @(negedge Clk);
            w++;
        end
        repeat (2) @(negedge Clk);
        chk({tag, ".nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            chk($sformatf("%s.addr%0d", tag, k), got_w[k][63:32], exp_w[k][63:32]);
            chk($sformatf("%s.data%0d", tag, k), got_w[k][31:0], exp_w[k][31:0]);
        end
        chk({tag, ".done"}, 32'(Done), 32'(exp_done));
        chk({tag, ".error"}, 32'(Error), 32'(exp_err));
        chk({tag, ".hold"}, 32'(CpuHold), 32'(!exp_done));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, 32'(ByteReady), 32'd0);
        chk({tag, ".we"}, 32'(WriteEnable), 32'd0);
        chk({tag, ".wdata"}, WriteData, 32'd0);
        chk({tag, ".waddr"}, WriteAddress, BASE);
        chk({tag, ".hold"}, 32'(CpuHold), 32'd0);
        chk({tag, ".done"}, 32'(Done), 32'd0);
        chk({tag, ".error"}, 32'(Error), 32'd0);
    endtask

    initial begin
        logic [7:0] s[$];
        logic [7:0] x;
        int cnt;

        repeat (3) @(negedge Clk);
        chk_reset_vals("rst");
        @(posedge Clk); #1;
        Rst_n = 1'b1;

        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(pay_xor(s));
`endif
        run_load("nom", s, 0, -1);
        chk("nom.spacing", 32'(strobe_c[1] - strobe_c[0]), 32'd4);
`ifndef LOADER_CHECKSUM_EN
        chk("nom.done_lat", 32'(done_cyc - strobe_c[1]), 32'd1);
`endif
        run_load("thr", s, 1, -1);
`ifndef LOADER_CHECKSUM_EN
        chk("thr.done_lat", 32'(done_cyc - strobe_c[1]), 32'd1);
`endif
        run_load("midstart", s, 0, 4);

        s = '{8'h04, 8'h01};
        run_load("ovf", s, 0, -1);

        s = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_load("zero", s, 0, -1);
        chk("zero.waddr", WriteAddress, BASE);

`ifdef LOADER_CHECKSUM_EN
        s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        run_load("csum_ok", s, 0, -1);
        s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        run_load("csum_bad", s, 0, -1);
`endif

        // Abort mid-payload, then reload from scratch.
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        s = '{8'h00, 8'h02, 8'h20, 8'h08};
        foreach (s[i]) send_byte("abort", s[i], 1'b0);
        ByteValid = 1'b0;
        Rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(pay_xor(s));
`endif
        run_load("reload", s, 0, -1);

        for (int r = 0; r < 6; r++) begin
            cnt = $urandom_range(0, 6);
            s = '{8'(cnt >> 8), 8'(cnt)};
            for (int i = 0; i < 4 * cnt; i++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            x = pay_xor(s);
            if ($urandom_range(0, 3) == 0) x ^= 8'h01;
            s.push_back(x);
`endif
            run_load($sformatf("rnd%0d", r), s, 2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
